// File: rtl/fft_stream_pkg.sv
// Shared constants for the FFT output stream: component widths, frame size and tdata field layout.
package fft_stream_pkg;

    localparam int DATA_W    = 16;
    localparam int NFFT_LOG2 = 10;
    localparam int RE_LSB    = 0;
    localparam int IM_LSB    = DATA_W;
    localparam int POW_W     = 2 * DATA_W;

    // Offset of the imaginary field for an arbitrary component width.
    function automatic int im_lsb_of(input int dw);
        return RE_LSB + dw;
    endfunction

endpackage

// File: rtl/fft_power_peak_if.sv
// AXI-Stream bundles around the power/peak block: complex input stream and tagged power output stream.
interface fft_in_if #(
    parameter int DATA_W = 16
);
    logic [2*DATA_W-1:0] tdata;
    logic                tvalid;
    logic                tready;
    logic                tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

interface fft_out_if #(
    parameter int DATA_W = 16,
    parameter int USER_W = 10
);
    logic [2*DATA_W-1:0] tdata;
    logic [USER_W-1:0]   tuser;
    logic                tvalid;
    logic                tready;
    logic                tlast;

    modport master (output tdata, output tuser, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tuser, input tvalid, input tlast, output tready);
endinterface

// File: rtl/cplx_power_pipe.sv
// Three-stage re^2 + im^2 pipeline with a global clock enable; a sideband word rides along with each beat.
module cplx_power_pipe #(
    parameter int DATA_W = 16,
    parameter int SIDE_W = 11
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_ce,
    input  logic                       i_valid,
    input  logic signed [DATA_W-1:0]   i_re,
    input  logic signed [DATA_W-1:0]   i_im,
    input  logic [SIDE_W-1:0]          i_side,
    output logic                       o_valid,
    output logic [2*DATA_W-1:0]        o_power,
    output logic [SIDE_W-1:0]          o_side
);
    localparam int PW = 2 * DATA_W;

    logic signed [DATA_W-1:0] r_re;
    logic signed [DATA_W-1:0] r_im;
    logic [PW-1:0]            r_re_sq;
    logic [PW-1:0]            r_im_sq;
    logic [PW-1:0]            r_pow;
    logic                     r_s1_valid;
    logic                     r_s2_valid;
    logic                     r_s3_valid;
    logic [SIDE_W-1:0]        r_s1_side;
    logic [SIDE_W-1:0]        r_s2_side;
    logic [SIDE_W-1:0]        r_s3_side;

    logic signed [PW-1:0]     w_re_ext;
    logic signed [PW-1:0]     w_im_ext;
    logic signed [PW-1:0]     w_re_sq;
    logic signed [PW-1:0]     w_im_sq;

    // Squares are never negative and peak at 2^(PW-2), so the PW-bit sum cannot overflow.
    assign w_re_ext = $signed({{DATA_W{r_re[DATA_W-1]}}, r_re});
    assign w_im_ext = $signed({{DATA_W{r_im[DATA_W-1]}}, r_im});
    assign w_re_sq  = w_re_ext * w_re_ext;
    assign w_im_sq  = w_im_ext * w_im_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_re       <= '0;
            r_im       <= '0;
            r_re_sq    <= '0;
            r_im_sq    <= '0;
            r_pow      <= '0;
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s3_valid <= 1'b0;
            r_s1_side  <= '0;
            r_s2_side  <= '0;
            r_s3_side  <= '0;
        end else if (i_ce) begin
            r_re       <= i_re;
            r_im       <= i_im;
            r_s1_valid <= i_valid;
            r_s1_side  <= i_side;
            r_re_sq    <= $unsigned(w_re_sq);
            r_im_sq    <= $unsigned(w_im_sq);
            r_s2_valid <= r_s1_valid;
            r_s2_side  <= r_s1_side;
            r_pow      <= r_re_sq + r_im_sq;
            r_s3_valid <= r_s2_valid;
            r_s3_side  <= r_s2_side;
        end
    end

    assign o_valid = r_s3_valid;
    assign o_power = r_pow;
    assign o_side  = r_s3_side;

endmodule

// File: rtl/fft_power_peak.sv
// FFT bin power stage: squares each complex bin, tags it with its bin index, and reports the strongest bin per frame.
module fft_power_peak #(
    parameter int DATA_W    = fft_stream_pkg::DATA_W,
    parameter int NFFT_LOG2 = fft_stream_pkg::NFFT_LOG2,
    parameter int SKIP_DC   = 1
) (
    input  logic                    aclk,
    input  logic                    areset,
    fft_in_if.slave                 s_axis_data,
    fft_out_if.master               m_axis_data,
    output logic                    peak_valid,
    output logic [NFFT_LOG2-1:0]    peak_bin,
    output logic [2*DATA_W-1:0]     peak_power,
    output logic                    frame_err
);
    import fft_stream_pkg::*;

    localparam int                   PW       = 2 * DATA_W;
    localparam int                   SIDE_W   = NFFT_LOG2 + 1;
    localparam int                   IM_OFS   = im_lsb_of(DATA_W);
    localparam logic [NFFT_LOG2-1:0] LAST_BIN = '1;

    logic [NFFT_LOG2-1:0] r_bin_cnt;
    logic                 r_frame_err;
    logic [PW-1:0]        r_max_pow;
    logic [NFFT_LOG2-1:0] r_max_bin;
    logic                 r_peak_valid;
    logic [NFFT_LOG2-1:0] r_peak_bin;
    logic [PW-1:0]        r_peak_power;

    logic                 w_ce;
    logic                 w_s_acc;
    logic                 w_cnt_last;
    logic                 w_m_valid;
    logic                 w_m_acc;
    logic [PW-1:0]        w_m_pow;
    logic [SIDE_W-1:0]    w_m_side;
    logic [NFFT_LOG2-1:0] w_m_bin;
    logic                 w_m_last;
    logic                 w_is_cand;
    logic [PW-1:0]        w_best_pow;
    logic [NFFT_LOG2-1:0] w_best_bin;

    // Whole pipeline freezes while the output beat is held, so bubbles keep their slots.
    assign w_ce              = !w_m_valid || m_axis_data.tready;
    assign s_axis_data.tready = w_ce && !areset;
    assign w_s_acc           = s_axis_data.tvalid && s_axis_data.tready;
    assign w_cnt_last        = (r_bin_cnt == LAST_BIN);

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_bin_cnt   <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            if (w_s_acc) begin
                r_frame_err <= (s_axis_data.tlast != w_cnt_last);
                if (s_axis_data.tlast || w_cnt_last) begin
                    r_bin_cnt <= '0;
                end else begin
                    r_bin_cnt <= r_bin_cnt + 1'b1;
                end
            end
        end
    end

    cplx_power_pipe #(
        .DATA_W (DATA_W),
        .SIDE_W (SIDE_W)
    ) u_pipe (
        .clk     (aclk),
        .rst     (areset),
        .i_ce    (w_ce),
        .i_valid (w_s_acc),
        .i_re    ($signed(s_axis_data.tdata[RE_LSB +: DATA_W])),
        .i_im    ($signed(s_axis_data.tdata[IM_OFS +: DATA_W])),
        .i_side  ({s_axis_data.tlast, r_bin_cnt}),
        .o_valid (w_m_valid),
        .o_power (w_m_pow),
        .o_side  (w_m_side)
    );

    assign w_m_bin  = w_m_side[NFFT_LOG2-1:0];
    assign w_m_last = w_m_side[NFFT_LOG2];
    assign w_m_acc  = w_m_valid && m_axis_data.tready;

    assign m_axis_data.tvalid = w_m_valid;
    assign m_axis_data.tdata  = w_m_pow;
    assign m_axis_data.tuser  = w_m_bin;
    assign m_axis_data.tlast  = w_m_last;

    // Strict compare keeps the lowest bin on ties.
    assign w_is_cand  = (w_m_pow > r_max_pow) && !((SKIP_DC != 0) && (w_m_bin == '0));
    assign w_best_pow = w_is_cand ? w_m_pow : r_max_pow;
    assign w_best_bin = w_is_cand ? w_m_bin : r_max_bin;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_max_pow    <= '0;
            r_max_bin    <= '0;
            r_peak_valid <= 1'b0;
            r_peak_bin   <= '0;
            r_peak_power <= '0;
        end else begin
            r_peak_valid <= 1'b0;
            if (w_m_acc) begin
                if (w_m_last) begin
                    r_peak_bin   <= w_best_bin;
                    r_peak_power <= w_best_pow;
                    r_peak_valid <= 1'b1;
                    r_max_pow    <= '0;
                    r_max_bin    <= '0;
                end else begin
                    r_max_pow <= w_best_pow;
                    r_max_bin <= w_best_bin;
                end
            end
        end
    end

    assign peak_valid = r_peak_valid;
    assign peak_bin   = r_peak_bin;
    assign peak_power = r_peak_power;
    assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_fft_power_peak.sv
// Scoreboard bench for fft_power_peak with an 8-bin frame.
module tb_fft_power_peak;
    localparam int DW = 16;
    localparam int NL = 3;
    localparam int N  = 8;
    localparam int PW = 32;

    typedef struct packed {
        logic [PW-1:0] pow;
        logic [NL-1:0] bin;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic [NL-1:0] bin;
        logic [PW-1:0] pow;
    } peak_t;

    logic aclk = 1'b0;
    logic areset = 1'b1;
    always #5 aclk = ~aclk;

    fft_in_if  #(.DATA_W(DW))              s_if ();
    fft_out_if #(.DATA_W(DW), .USER_W(NL)) m_if ();

    logic          peak_valid;
    logic [NL-1:0] peak_bin;
    logic [PW-1:0] peak_power;
    logic          frame_err;

    fft_power_peak #(.DATA_W(DW), .NFFT_LOG2(NL), .SKIP_DC(1)) dut (
        .aclk        (aclk),
        .areset      (areset),
        .s_axis_data (s_if),
        .m_axis_data (m_if),
        .peak_valid  (peak_valid),
        .peak_bin    (peak_bin),
        .peak_power  (peak_power),
        .frame_err   (frame_err)
    );

    beat_t         exp_q[$];
    peak_t         peak_q[$];
    int            checks = 0;
    int            failures = 0;
    int            tb_cnt = 0;
    logic [PW-1:0] mx = '0;
    logic [NL-1:0] mxb = '0;
    bit            bp_en = 1'b0;

    task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        peak_q.delete();
        tb_cnt = 0;
        mx = '0;
        mxb = '0;
    endtask

    task automatic send_beat(input logic signed [DW-1:0] re, input logic signed [DW-1:0] im,
                             input logic last);
        int            n;
        bit            ok;
        longint        p;
        logic [PW-1:0] pw;
        logic [NL-1:0] b;
        bit            cl;
        bit            e;
        n = 0;
        ok = 1'b0;
        s_if.tdata  = {im, re};
        s_if.tlast  = last;
        s_if.tvalid = 1'b1;
        while (!ok && n < 1000) begin
            @(negedge aclk);
            if (s_if.tready) ok = 1'b1;
            else n++;
        end
        if (!ok) begin
            chk_eq("accept_timeout", 0, 1);
            s_if.tvalid = 1'b0;
            return;
        end
        @(posedge aclk);
        p  = longint'(re) * longint'(re) + longint'(im) * longint'(im);
        pw = p[PW-1:0];
        b  = tb_cnt[NL-1:0];
        cl = (tb_cnt == N - 1);
        e  = (last != cl);
        exp_q.push_back('{pw, b, last});
        if (b != 0 && pw > mx) begin
            mx  = pw;
            mxb = b;
        end
        if (last) begin
            peak_q.push_back('{mxb, mx});
            mx  = '0;
            mxb = '0;
        end
        tb_cnt = (last || cl) ? 0 : tb_cnt + 1;
        #1;
        chk_eq("frame_err", frame_err, e);
        s_if.tvalid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || peak_q.size() != 0) && n < 500) begin
            @(negedge aclk);
            n++;
        end
        chk_eq("drain_beats", exp_q.size(), 0);
        chk_eq("drain_peaks", peak_q.size(), 0);
        @(posedge aclk);
        #1;
    endtask

    always @(posedge aclk) begin
        #1;
        m_if.tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Every cycle a beat is presented it must match the queue head, which also proves stability under stall.
    always @(negedge aclk) begin
        if (!areset && m_if.tvalid) begin
            if (exp_q.size() == 0) begin
                chk_eq("beat_unexpected", 1, 0);
            end else begin
                chk_eq("tdata", m_if.tdata, exp_q[0].pow);
                chk_eq("tuser", m_if.tuser, exp_q[0].bin);
                chk_eq("tlast", m_if.tlast, exp_q[0].last);
                if (m_if.tready) void'(exp_q.pop_front());
            end
        end
        if (!areset && peak_valid) begin
            if (peak_q.size() == 0) begin
                chk_eq("peak_unexpected", 1, 0);
            end else begin
                chk_eq("peak_bin", peak_bin, peak_q[0].bin);
                chk_eq("peak_power", peak_power, peak_q[0].pow);
                void'(peak_q.pop_front());
            end
        end
    end

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;

        repeat (3) begin
            @(posedge aclk);
            @(negedge aclk);
            chk_eq("rst_s_tready", s_if.tready, 0);
            chk_eq("rst_m_tvalid", m_if.tvalid, 0);
            chk_eq("rst_m_tdata", m_if.tdata, 0);
            chk_eq("rst_peak_valid", peak_valid, 0);
            chk_eq("rst_peak_bin", peak_bin, 0);
            chk_eq("rst_peak_power", peak_power, 0);
            chk_eq("rst_frame_err", frame_err, 0);
        end
        @(posedge aclk);
        #1;
        areset = 1'b0;
        @(negedge aclk);
        chk_eq("post_rst_s_tready", s_if.tready, 1);
        @(posedge aclk);
        #1;

        // Arithmetic corners, padded out to a full frame.
        send_beat(16'sd3, 16'sd4, 1'b0);
        send_beat(-16'sd32768, -16'sd32768, 1'b0);
        send_beat(-16'sd1, 16'sd0, 1'b0);
        for (int i = 3; i < N; i++) send_beat(16'(i), -16'(i), (i == N - 1));
        drain();
        chk_eq("arith_peak_bin", peak_bin, 1);
        chk_eq("arith_peak_pow", peak_power, 64'h8000_0000);

        // DC bin is loudest but skipped; bins 3 and 5 tie and the lower wins.
        send_beat(16'sd31, 16'sd31, 1'b0);
        send_beat(16'sd0, 16'sd0, 1'b0);
        send_beat(16'sd0, 16'sd0, 1'b0);
        send_beat(16'sd3, 16'sd4, 1'b0);
        send_beat(16'sd0, 16'sd0, 1'b0);
        send_beat(-16'sd5, 16'sd0, 1'b0);
        send_beat(16'sd0, 16'sd0, 1'b0);
        send_beat(16'sd0, 16'sd0, 1'b1);
        drain();
        chk_eq("peak_frame_bin", peak_bin, 3);
        chk_eq("peak_frame_pow", peak_power, 25);

        // Early tlast, then a missing tlast that wraps the counter, then a clean frame.
        for (int i = 0; i < 6; i++) send_beat(16'(i + 1), 16'(2 * i), (i == 5));
        for (int i = 0; i < N; i++) send_beat(16'(10 - i), 16'(i), 1'b0);
        for (int i = 0; i < N; i++) send_beat(16'(i * 7), -16'(i), (i == N - 1));
        drain();

        bp_en = 1'b1;
        for (int f = 0; f < 4; f++)
            for (int i = 0; i < N; i++)
                send_beat(16'($urandom), 16'($urandom), (i == N - 1));
        drain();
        bp_en = 1'b0;

        // Reset in the middle of a frame drops it silently.
        for (int i = 0; i < 4; i++) send_beat(16'(100 + i), 16'(i), 1'b0);
        areset = 1'b1;
        model_clear();
        repeat (2) begin
            @(negedge aclk);
            chk_eq("midrst_s_tready", s_if.tready, 0);
            @(posedge aclk);
        end
        #1;
        chk_eq("midrst_m_tvalid", m_if.tvalid, 0);
        chk_eq("midrst_peak_valid", peak_valid, 0);
        areset = 1'b0;
        for (int i = 0; i < N; i++) send_beat(16'(i == 6 ? 50 : i), 16'(i), (i == N - 1));
        drain();
        chk_eq("after_rst_peak_bin", peak_bin, 6);
        chk_eq("after_rst_peak_pow", peak_power, 2536);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
